ctrl_sequencer: RTL and testbench

Multicycle control sequencer for the MIPS-subset CPU. It steps fetch/decode/execute/memory/writeback states and drives the datapath select and enable lines, including the 3-bit ALU-B operand mux selector and the ALU-A selector. Outputs are decoded from the registered state; the only exceptions are the memory-handshake-gated enables and the branch PC write. It sits between the instruction register fields and the datapath.

---
 rtl/ctrl_pkg.sv | 54 +++++
 rtl/alu_funct_dec.sv | 24 ++
 rtl/ctrl_sequencer.sv | 176 +++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: states, datapath
// select codes, ALU operations and the supported opcode/funct values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_ILLEGAL
  } state_t;

  localparam logic [1:0] ULAA_PC   = 2'b00;
  localparam logic [1:0] ULAA_REGA = 2'b01;

  localparam logic [2:0] ULAB_FOUR    = 3'b000;
  localparam logic [2:0] ULAB_REGB    = 3'b001;
  localparam logic [2:0] ULAB_IMM_SH2 = 3'b010;
  localparam logic [2:0] ULAB_IMM     = 3'b011;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/alu_funct_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags whether the
// funct is one the sequencer supports.
module alu_funct_dec
  import ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       valid
);

  always_comb begin
    alu_ctrl = ALU_NOP;
    valid    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multicycle MIPS-subset control FSM; outputs decode from the registered state,
// except the mem_rdy-gated enables and the branch pc_write.
//
//   state    | meaning
//   RST      | post-reset idle cycle, all outputs quiet
//   FETCH    | read instruction at PC, PC <= PC+4 on mem_rdy
//   DECODE   | latch A/B, precompute branch target, dispatch on opcode
//   EXEC_R   | A op B for R-type
//   WB_R     | write ALUOut to rd
//   EXEC_I   | A + imm for addi
//   WB_I     | write ALUOut to rt
//   MEM_ADDR | A + imm address for lw/sw
//   MEM_RD   | load access, waits for mem_rdy
//   WB_MEM   | write MDR to rt
//   MEM_WR   | store access, waits for mem_rdy
//   BRANCH   | beq compare, PC <= ALUOut when equal
//   JUMP     | PC <= jump target
//   ILLEGAL  | unsupported instruction, held until reset
module ctrl_sequencer
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_rdy,
  output logic [1:0] ulaA_sel,
  output logic [2:0] ulaB_sel,
  output logic [2:0] alu_ctrl,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       a_b_write,
  output logic       aluout_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal
);

  state_t     state, state_nxt;
  logic [2:0] dec_alu_ctrl;
  logic       dec_valid;

  alu_funct_dec u_alu_funct_dec (
    .funct    (funct),
    .alu_ctrl (dec_alu_ctrl),
    .valid    (dec_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RST;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ulaA_sel     = ULAA_PC;
    ulaB_sel     = ULAB_FOUR;
    alu_ctrl     = ALU_NOP;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_ALU;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    a_b_write    = 1'b0;
    aluout_write = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    illegal      = 1'b0;

    case (state)
      S_RST: state_nxt = S_FETCH;

      S_FETCH: begin
        mem_read = 1'b1;
        alu_ctrl = ALU_ADD;
        ir_write = mem_rdy;
        pc_write = mem_rdy;
        if (mem_rdy) state_nxt = S_DECODE;
      end

      S_DECODE: begin
        ulaB_sel     = ULAB_IMM_SH2;
        alu_ctrl     = ALU_ADD;
        aluout_write = 1'b1;
        a_b_write    = 1'b1;
        case (opcode)
          OP_RTYPE:     state_nxt = dec_valid ? S_EXEC_R : S_ILLEGAL;
          OP_ADDI:      state_nxt = S_EXEC_I;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_ILLEGAL;
        endcase
      end

      S_EXEC_R: begin
        ulaA_sel     = ULAA_REGA;
        ulaB_sel     = ULAB_REGB;
        alu_ctrl     = dec_alu_ctrl;
        aluout_write = 1'b1;
        state_nxt    = S_WB_R;
      end

      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_nxt = S_FETCH;
      end

      S_EXEC_I, S_MEM_ADDR: begin
        ulaA_sel     = ULAA_REGA;
        ulaB_sel     = ULAB_IMM;
        alu_ctrl     = ALU_ADD;
        aluout_write = 1'b1;
        if (state == S_EXEC_I)    state_nxt = S_WB_I;
        else if (opcode == OP_LW) state_nxt = S_MEM_RD;
        else if (opcode == OP_SW) state_nxt = S_MEM_WR;
        else                      state_nxt = S_ILLEGAL;
      end

      S_WB_I: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end

      S_MEM_RD: begin
        mem_read  = 1'b1;
        iord      = 1'b1;
        mdr_write = mem_rdy;
        if (mem_rdy) state_nxt = S_WB_MEM;
      end

      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_rdy) state_nxt = S_FETCH;
      end

      S_BRANCH: begin
        ulaA_sel  = ULAA_REGA;
        ulaB_sel  = ULAB_REGB;
        alu_ctrl  = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = alu_zero;
        state_nxt = S_FETCH;
      end

      S_JUMP: begin
        pc_src    = PC_SRC_JUMP;
        pc_write  = 1'b1;
        state_nxt = S_FETCH;
      end

      S_ILLEGAL: illegal = 1'b1;

      default: state_nxt = S_RST;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: per-cycle expected output vectors
// are queued with the stimulus and compared at the falling edge.
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_rdy;
  logic [1:0] ulaA_sel, pc_src;
  logic [2:0] ulaB_sel, alu_ctrl;
  logic       pc_write, ir_write, mdr_write, a_b_write, aluout_write;
  logic       mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, illegal;
  logic [21:0] obs;

  int errors = 0;
  int checks = 0;

  logic [21:0] exp_q[$];
  logic        rdy_q[$];
  logic        zero_q[$];
  string       nm_q[$];

  always #5 clk = ~clk;

  ctrl_sequencer dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_rdy(mem_rdy),
    .ulaA_sel(ulaA_sel), .ulaB_sel(ulaB_sel), .alu_ctrl(alu_ctrl),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .mdr_write(mdr_write), .a_b_write(a_b_write), .aluout_write(aluout_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal)
  );

  assign obs = {ulaA_sel, ulaB_sel, alu_ctrl, pc_write, pc_src,
                ir_write, mdr_write, a_b_write, aluout_write, mem_read, mem_write,
                iord, reg_write, reg_dst, mem_to_reg, illegal};

  // en = {ir, mdr, a_b, aluout, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, illegal}
  function automatic logic [21:0] pk(input logic [1:0] a, input logic [2:0] b,
                                     input logic [2:0] alu, input logic pcw,
                                     input logic [1:0] pcs, input logic [10:0] en);
    return {a, b, alu, pcw, pcs, en};
  endfunction

  function automatic logic [21:0] e_fetch(input logic r);
    return pk(2'b00, 3'b000, 3'b001, r, 2'b00, {r, 3'b000, 1'b1, 6'b000000});
  endfunction
  function automatic logic [21:0] e_dec();
    return pk(2'b00, 3'b010, 3'b001, 1'b0, 2'b00, 11'b00110000000);
  endfunction
  function automatic logic [21:0] e_execr(input logic [2:0] alu);
    return pk(2'b01, 3'b001, alu, 1'b0, 2'b00, 11'b00010000000);
  endfunction
  function automatic logic [21:0] e_addr();
    return pk(2'b01, 3'b011, 3'b001, 1'b0, 2'b00, 11'b00010000000);
  endfunction
  function automatic logic [21:0] e_wb(input logic rd, input logic m2r);
    return pk(2'b00, 3'b000, 3'b000, 1'b0, 2'b00, {7'b0000000, 1'b1, rd, m2r, 1'b0});
  endfunction
  function automatic logic [21:0] e_memrd(input logic r);
    return pk(2'b00, 3'b000, 3'b000, 1'b0, 2'b00, {1'b0, r, 2'b00, 1'b1, 1'b0, 1'b1, 4'b0000});
  endfunction
  function automatic logic [21:0] e_memwr();
    return pk(2'b00, 3'b000, 3'b000, 1'b0, 2'b00, 11'b00000110000);
  endfunction
  function automatic logic [21:0] e_br(input logic z);
    return pk(2'b01, 3'b001, 3'b010, z, 2'b01, 11'b0);
  endfunction
  function automatic logic [21:0] e_j();
    return pk(2'b00, 3'b000, 3'b000, 1'b1, 2'b10, 11'b0);
  endfunction
  function automatic logic [21:0] e_ill();
    return pk(2'b00, 3'b000, 3'b000, 1'b0, 2'b00, 11'b00000000001);
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic r, input logic z, input logic [21:0] e, input string nm);
    rdy_q.push_back(r);
    zero_q.push_back(z);
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // One cycle of stimulus: inputs change just after the rising edge.
  task automatic drive_next();
    @(posedge clk);
    #1;
    mem_rdy  = rdy_q.pop_front();
    alu_zero = zero_q.pop_front();
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [21:0] e;
    string nm;
    mem_rdy = 1'b1; alu_zero = 1'b0; opcode = 6'h00; funct = 6'h20;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    checks++;
    if (obs !== 22'd0) begin errors++; $display("FAIL reset_async: got %h expected %h", obs, 22'd0); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 22'd0) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs, 22'd0); end
    release_reset();
    checks++;
    if (obs !== 22'd0) begin errors++; $display("FAIL rst_cycle: got %h expected %h", obs, 22'd0); end
    add(1'b0, 1'b0, e_fetch(1'b0), "fetch_wait0");
    add(1'b0, 1'b0, e_fetch(1'b0), "fetch_wait1");
    while (exp_q.size() > 0) begin
      drive_next();
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0] op [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
    logic [21:0] e;
    string nm;
    for (int i = 0; i < 5; i++) begin
      opcode = 6'h00; funct = fn[i];
      add(1'b1, 1'b0, e_fetch(1'b1), "r_fetch");
      add(rnd(), rnd(), e_dec(), "r_decode");
      add(rnd(), rnd(), e_execr(op[i]), $sformatf("r_exec_%h", fn[i]));
      add(rnd(), rnd(), e_wb(1'b1, 1'b0), "r_wb");
      while (exp_q.size() > 0) begin
        drive_next();
        e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
      end
    end
  endtask

  task automatic test_mem();
    logic [21:0] e;
    string nm;
    opcode = 6'h08; funct = 6'h3F;
    add(1'b1, 1'b0, e_fetch(1'b1), "addi_fetch");
    add(rnd(), 1'b0, e_dec(), "addi_decode");
    add(rnd(), 1'b0, e_addr(), "addi_exec");
    add(rnd(), 1'b0, e_wb(1'b0, 1'b0), "addi_wb");
    while (exp_q.size() > 0) begin
      drive_next();
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
    end
    opcode = 6'h23;
    add(1'b0, 1'b0, e_fetch(1'b0), "lw_fetch_wait");
    add(1'b1, 1'b0, e_fetch(1'b1), "lw_fetch");
    add(1'b0, 1'b0, e_dec(), "lw_decode");
    add(1'b0, 1'b0, e_addr(), "lw_addr");
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, e_memrd(1'b0), "lw_rd_wait");
    add(1'b1, 1'b0, e_memrd(1'b1), "lw_rd_done");
    add(1'b1, 1'b0, e_wb(1'b0, 1'b1), "lw_wb");
    while (exp_q.size() > 0) begin
      drive_next();
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
    end
    opcode = 6'h2B;
    add(1'b1, 1'b0, e_fetch(1'b1), "sw_fetch");
    add(1'b0, 1'b0, e_dec(), "sw_decode");
    add(1'b0, 1'b0, e_addr(), "sw_addr");
    add(1'b0, 1'b0, e_memwr(), "sw_wr_wait");
    add(1'b1, 1'b0, e_memwr(), "sw_wr_done");
    while (exp_q.size() > 0) begin
      drive_next();
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
    end
  endtask

  task automatic test_branch_jump();
    logic [21:0] e;
    string nm;
    opcode = 6'h04;
    add(1'b1, 1'b0, e_fetch(1'b1), "beq1_fetch");
    add(1'b0, 1'b0, e_dec(), "beq1_decode");
    add(1'b0, 1'b1, e_br(1'b1), "beq_taken");
    add(1'b1, 1'b0, e_fetch(1'b1), "beq0_fetch");
    add(1'b1, 1'b1, e_dec(), "beq0_decode");
    add(1'b1, 1'b0, e_br(1'b0), "beq_not_taken");
    while (exp_q.size() > 0) begin
      drive_next();
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
    end
    opcode = 6'h02;
    add(1'b1, 1'b0, e_fetch(1'b1), "j_fetch");
    add(rnd(), 1'b0, e_dec(), "j_decode");
    add(rnd(), 1'b0, e_j(), "j_jump");
    while (exp_q.size() > 0) begin
      drive_next();
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
    end
  endtask

  task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn, input int n);
    logic [21:0] e;
    string nm;
    opcode = op; funct = fn;
    add(1'b1, 1'b0, e_fetch(1'b1), "ill_fetch");
    add(1'b1, 1'b0, e_dec(), "ill_decode");
    for (int i = 0; i < n; i++) add(1'(i % 2), rnd(), e_ill(), $sformatf("ill_hold_%0d", i));
    while (exp_q.size() > 0) begin
      drive_next();
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL ill_clear: got %b expected 0", illegal); end
    release_reset();
    checks++;
    if (obs !== 22'd0) begin errors++; $display("FAIL ill_rst_cycle: got %h expected %h", obs, 22'd0); end
  endtask

  task automatic test_reset_midaccess();
    logic [21:0] e;
    string nm;
    opcode = 6'h2B; funct = 6'h00;
    add(1'b1, 1'b0, e_fetch(1'b1), "mid_fetch");
    add(1'b0, 1'b0, e_dec(), "mid_decode");
    add(1'b0, 1'b0, e_addr(), "mid_addr");
    add(1'b0, 1'b0, e_memwr(), "mid_wr_wait");
    while (exp_q.size() > 0) begin
      drive_next();
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || obs !== 22'd0) begin
      errors++; $display("FAIL mid_reset_drop: got %h expected %h", obs, 22'd0);
    end
    release_reset();
    checks++;
    if (obs !== 22'd0) begin errors++; $display("FAIL mid_rst_cycle: got %h expected %h", obs, 22'd0); end
    opcode = 6'h02;
    add(1'b1, 1'b0, e_fetch(1'b1), "mid_restart_fetch");
    add(1'b0, 1'b0, e_dec(), "mid_restart_decode");
    add(1'b0, 1'b0, e_j(), "mid_restart_jump");
    while (exp_q.size() > 0) begin
      drive_next();
      e = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch_jump();
    test_illegal(6'h3F, 6'h20, 20);
    test_illegal(6'h00, 6'h03, 20);
    test_reset_midaccess();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
